// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM encoding and
// alignment helper used by the target adders and the top level.
package pc_seq_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } seq_state_t;

    // Number of low address bits that must be zero for an INST_BYTES-aligned address.
    function automatic int align_lsb(input int inst_bytes);
        return (inst_bytes <= 1) ? 0 : $clog2(inst_bytes);
    endfunction

endpackage

// File: rtl/pc_target_adder.sv
// XLEN-wide wrapping adder with an optional INST_BYTES alignment check on the sum.
module pc_target_adder
    import pc_seq_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int INST_BYTES  = 4,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] sum,
    output logic            misaligned
);

    localparam int              LSB  = align_lsb(INST_BYTES);
    localparam logic [XLEN-1:0] MASK = XLEN'((64'd1 << LSB) - 64'd1);

    assign sum        = a + b;
    assign misaligned = ALIGN_CHECK && ((sum & MASK) != '0);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: BOOT/RUN/TRAP sequencing, prioritised jump/branch/stall
// redirects, registered PC+INST_BYTES, and trap entry on misaligned redirect targets.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INST_BYTES   = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter bit              ALIGN_CHECK  = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump_valid,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap_ack,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            trap_pending,
    output logic [XLEN-1:0] trap_addr,
    output logic [ST_W-1:0] seq_state
);

    localparam int              LSB      = align_lsb(INST_BYTES);
    localparam logic [XLEN-1:0] VEC_MASK = XLEN'((64'd1 << LSB) - 64'd1);

    seq_state_t      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] seq_q, seq_d;
    logic [XLEN-1:0] trap_addr_q, trap_addr_d;
    logic            trap_q, trap_d;

    logic [XLEN-1:0] tgt_a, tgt_b, tgt;
    logic            tgt_misaligned;
    logic            seq_misaligned;

    // Jump has priority, so feeding it through the same adder with a zero
    // addend gives one target and one alignment check for both redirect kinds.
    assign tgt_a = jump_valid ? jump_target : branch_pc;
    assign tgt_b = jump_valid ? '0 : branch_offset;

    pc_target_adder #(
        .XLEN        (XLEN),
        .INST_BYTES  (INST_BYTES),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_redirect_adder (
        .a          (tgt_a),
        .b          (tgt_b),
        .sum        (tgt),
        .misaligned (tgt_misaligned)
    );

    // Increment is taken from the next PC so pc_next_seq lands on the same edge as pc_out.
    pc_target_adder #(
        .XLEN        (XLEN),
        .INST_BYTES  (INST_BYTES),
        .ALIGN_CHECK (ALIGN_CHECK)
    ) u_seq_adder (
        .a          (pc_d),
        .b          (XLEN'(INST_BYTES)),
        .sum        (seq_d),
        .misaligned (seq_misaligned)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        trap_d      = trap_q;
        trap_addr_d = trap_addr_q;
        pc_valid    = 1'b0;

        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                pc_valid = 1'b1;
                if (jump_valid || branch_taken) begin
                    if (tgt_misaligned) begin
                        pc_d        = TRAP_VECTOR;
                        trap_addr_d = tgt;
                        trap_d      = 1'b1;
                        state_d     = TRAP;
                    end else begin
                        pc_d = tgt;
                    end
                end else if (!stall) begin
                    pc_d = seq_q;
                end
            end
            TRAP: begin
                if (trap_ack) begin
                    trap_d  = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_VECTOR;
            seq_q       <= RESET_VECTOR + XLEN'(INST_BYTES);
            trap_q      <= 1'b0;
            trap_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            seq_q       <= seq_d;
            trap_q      <= trap_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign pc_out       = pc_q;
    assign pc_next_seq  = seq_q;
    assign trap_pending = trap_q;
    assign trap_addr    = trap_addr_q;
    assign seq_state    = state_q;

    a_vectors_aligned: assert property (@(posedge clk)
        reset |-> (((RESET_VECTOR & VEC_MASK) == '0) && ((TRAP_VECTOR & VEC_MASK) == '0)));

    // From aligned vectors the sequential path can only produce aligned addresses.
    a_seq_aligned: assert property (@(posedge clk) disable iff (reset) !seq_misaligned);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, with two DUTs
// (alignment check on and off) compared every cycle against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_pc = '0;
    logic [31:0] branch_offset = '0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = '0;
    logic        trap_ack = 1'b0;

    logic [31:0] pc_out       [2];
    logic [31:0] pc_next_seq  [2];
    logic        pc_valid     [2];
    logic        trap_pending [2];
    logic [31:0] trap_addr    [2];
    logic [1:0]  seq_state    [2];

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer #(.ALIGN_CHECK(1'b1)) dut_chk (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .trap_ack      (trap_ack),
        .pc_out        (pc_out[0]),
        .pc_next_seq   (pc_next_seq[0]),
        .pc_valid      (pc_valid[0]),
        .trap_pending  (trap_pending[0]),
        .trap_addr     (trap_addr[0]),
        .seq_state     (seq_state[0])
    );

    pc_sequencer #(.ALIGN_CHECK(1'b0)) dut_nochk (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_pc     (branch_pc),
        .branch_offset (branch_offset),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .trap_ack      (trap_ack),
        .pc_out        (pc_out[1]),
        .pc_next_seq   (pc_next_seq[1]),
        .pc_valid      (pc_valid[1]),
        .trap_pending  (trap_pending[1]),
        .trap_addr     (trap_addr[1]),
        .seq_state     (seq_state[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the sequencer is either booting, trapped, or fetching at pc.
    typedef struct {
        bit          booting;
        bit          trapped;
        logic [31:0] pc;
        logic [31:0] taddr;
    } model_t;

    model_t m [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] tgt;
            if (reset) begin
                m[k].booting = 1'b1;
                m[k].trapped = 1'b0;
                m[k].pc      = 32'h0;
                m[k].taddr   = 32'h0;
            end else if (m[k].booting) begin
                m[k].booting = 1'b0;
            end else if (m[k].trapped) begin
                if (trap_ack) m[k].trapped = 1'b0;
            end else if (jump_valid || branch_taken) begin
                tgt = jump_valid ? jump_target : branch_pc + branch_offset;
                if (k == 0 && tgt % 4 != 0) begin
                    m[k].trapped = 1'b1;
                    m[k].taddr   = tgt;
                    m[k].pc      = 32'h100;
                end else begin
                    m[k].pc = tgt;
                end
            end else if (!stall) begin
                m[k].pc = m[k].pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("pc_out[%0d]", k), pc_out[k], m[k].pc);
                check($sformatf("pc_next_seq[%0d]", k), pc_next_seq[k], m[k].pc + 32'd4);
                check($sformatf("pc_valid[%0d]", k), {31'b0, pc_valid[k]},
                      {31'b0, !m[k].booting && !m[k].trapped});
                check($sformatf("trap_pending[%0d]", k), {31'b0, trap_pending[k]},
                      {31'b0, m[k].trapped});
                check($sformatf("trap_addr[%0d]", k), trap_addr[k], m[k].taddr);
                check($sformatf("seq_state[%0d]", k), {30'b0, seq_state[k]},
                      m[k].booting ? 32'd0 : (m[k].trapped ? 32'd2 : 32'd1));
            end
        end
    end

    task automatic clear_inputs();
        stall = 1'b0; branch_taken = 1'b0; jump_valid = 1'b0; trap_ack = 1'b0;
        branch_pc = '0; branch_offset = '0; jump_target = '0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        jump_valid = 1'b1; jump_target = t;
        tick();
        clear_inputs();
    endtask

    initial begin
        logic [31:0] r;
        // T1: reset, BOOT, then sequential fetch
        do_reset();
        started = 1'b1;
        check("t1_boot_state", {30'b0, seq_state[0]}, 32'd0);
        check("t1_boot_valid", {31'b0, pc_valid[0]}, 32'd0);
        check("t1_boot_pc", pc_out[0], 32'h0);
        check("t1_boot_seq", pc_next_seq[0], 32'h4);
        tick();
        check("t1_run_pc0", pc_out[0], 32'h0);
        check("t1_run_valid", {31'b0, pc_valid[0]}, 32'd1);
        tick();
        check("t1_pc4", pc_out[0], 32'h4);
        tick();
        check("t1_pc8", pc_out[0], 32'h8);
        check("t1_seq_c", pc_next_seq[0], 32'hC);
        tick(); tick();
        check("t2_at_0x10", pc_out[0], 32'h10);

        // T2: jump beats branch, branch beats stall
        jump_valid = 1'b1; jump_target = 32'h200;
        branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = 32'h40;
        tick();
        check("t2_jump_wins", pc_out[0], 32'h200);
        clear_inputs();
        stall = 1'b1; branch_taken = 1'b1; branch_pc = 32'h200; branch_offset = -32'sd8;
        tick();
        check("t2_branch_over_stall", pc_out[0], 32'h1F8);
        clear_inputs();

        // T3: stall for three cycles
        jump_to(32'h20);
        stall = 1'b1;
        repeat (3) begin
            tick();
            check("t3_stall_pc", pc_out[0], 32'h20);
            check("t3_stall_valid", {31'b0, pc_valid[0]}, 32'd1);
        end
        stall = 1'b0;
        tick();
        check("t3_release", pc_out[0], 32'h24);

        // T4: misaligned jump traps; ALIGN_CHECK=0 instance just jumps
        jump_to(32'h202);
        check("t4_trap_pc", pc_out[0], 32'h100);
        check("t4_trap_pending", {31'b0, trap_pending[0]}, 32'd1);
        check("t4_trap_addr", trap_addr[0], 32'h202);
        check("t4_trap_valid", {31'b0, pc_valid[0]}, 32'd0);
        check("t6_nochk_pc", pc_out[1], 32'h202);
        check("t6_nochk_notrap", {31'b0, trap_pending[1]}, 32'd0);
        branch_taken = 1'b1; branch_pc = 32'h400; branch_offset = 32'h8;
        tick(); tick();
        check("t4_branch_ignored", pc_out[0], 32'h100);
        clear_inputs();
        trap_ack = 1'b1;
        tick();
        clear_inputs();
        check("t4_ack_pc", pc_out[0], 32'h100);
        check("t4_ack_valid", {31'b0, pc_valid[0]}, 32'd1);
        check("t4_ack_cleared", {31'b0, trap_pending[0]}, 32'd0);
        check("t4_addr_kept", trap_addr[0], 32'h202);
        tick();
        check("t4_after_ack", pc_out[0], 32'h104);

        // T5: wrap on sequential and branch paths
        jump_to(32'hFFFF_FFFC);
        check("t5_seq_wrap_next", pc_next_seq[0], 32'h0);
        tick();
        check("t5_seq_wrap", pc_out[0], 32'h0);
        branch_taken = 1'b1; branch_pc = 32'hFFFF_FFF0; branch_offset = 32'h20;
        tick();
        clear_inputs();
        check("t5_branch_wrap", pc_out[0], 32'h10);

        // T6: reset while trapped
        jump_to(32'h7);
        check("t6_in_trap", {30'b0, seq_state[0]}, 32'd2);
        do_reset();
        check("t6_reset_trap", {31'b0, trap_pending[0]}, 32'd0);
        check("t6_reset_pc", pc_out[0], 32'h0);
        check("t6_reset_state", {30'b0, seq_state[0]}, 32'd0);
        check("t6_reset_taddr", trap_addr[0], 32'h0);

        // Random traffic, checked every cycle by the model comparison
        repeat (600) begin
            jump_valid   = ($urandom_range(0, 99) < 12);
            branch_taken = ($urandom_range(0, 99) < 15);
            stall        = ($urandom_range(0, 99) < 25);
            trap_ack     = ($urandom_range(0, 99) < 30);
            reset        = ($urandom_range(0, 199) == 0);
            r = $urandom();
            jump_target = ($urandom_range(0, 9) == 0) ? r : {r[31:2], 2'b00};
            r = $urandom();
            branch_pc = {r[31:2], 2'b00};
            r = $urandom_range(0, 511);
            branch_offset = ($urandom_range(0, 9) == 0) ? r - 32'd256 : {r[31:2], 2'b00} - 32'd256;
            tick();
        end
        clear_inputs();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
